// File: rtl/cipher_regfile_pkg.sv
// rtl/cipher_regfile_pkg.sv - register map, CTRL/STATUS bit positions and commit FSM states
package cipher_regfile_pkg;
   localparam int ADDR_SELECT = 'h00;
   localparam int ADDR_CTRL   = 'h02;
   localparam int ADDR_STATUS = 'h04;

   localparam int CTRL_COMMIT = 0;
   localparam int CTRL_LOCK   = 1;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;
endpackage

// File: rtl/cipher_regfile_commit_ctrl.sv
// rtl/cipher_regfile_commit_ctrl.sv - commit FSM: defers the shadow-to-active copy until busy drops
module cipher_regfile_commit_ctrl
   import cipher_regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       commit_req,
   input  logic       busy,
   output logic       pending,
   output logic       apply,
   output logic [7:0] commit_count
);
   state_t state;

   assign pending = (state == ST_PENDING);
   // apply is combinational so the copy lands on the same edge the FSM leaves PENDING
   assign apply   = pending && !busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         commit_count <= 8'd0;
      end else begin
         case (state)
            ST_IDLE:    if (commit_req) state <= ST_PENDING;
            ST_PENDING: if (!busy) begin
               state        <= ST_IDLE;
               commit_count <= commit_count + 8'd1;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/cipher_regfile.sv
// rtl/cipher_regfile.sv - shadow/active cipher select and key registers with atomic deferred commit
module cipher_regfile
   import cipher_regfile_pkg::*;
#(
   parameter int                              ADDR_WIDTH = 8,
   parameter int                              REG_WIDTH  = 16,
   parameter int                              NUM_KEYS   = 3,
   parameter logic [ADDR_WIDTH-1:0]           KEY_BASE   = 8'h10,
   parameter int                              KEY_STRIDE = 2,
   parameter logic [NUM_KEYS*REG_WIDTH-1:0]   KEY_RST    = {16'h2, 16'hFFFF, 16'h0}
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic                           read,
   input  logic                           write,
   input  logic [REG_WIDTH-1:0]           wdata,
   input  logic                           busy,
   output logic [REG_WIDTH-1:0]           rdata,
   output logic                           done,
   output logic                           error,
   output logic [REG_WIDTH-1:0]           select,
   output logic [NUM_KEYS*REG_WIDTH-1:0]  keys
);
   localparam int SEL_W = $clog2(NUM_KEYS);

   logic [SEL_W-1:0]     sel_sh, sel_act;
   logic [REG_WIDTH-1:0] key_sh  [NUM_KEYS];
   logic [REG_WIDTH-1:0] key_act [NUM_KEYS];
   logic                 lock;
   logic                 pending, apply;
   logic [7:0]           commit_count;

   logic                 is_sel, is_ctrl, is_status, key_hit;
   logic [NUM_KEYS-1:0]  key_sel;
   logic [REG_WIDTH-1:0] key_rd, rd_val;
   logic                 err, wr_ok, commit_req;

   assign is_sel    = (addr == ADDR_WIDTH'(ADDR_SELECT));
   assign is_ctrl   = (addr == ADDR_WIDTH'(ADDR_CTRL));
   assign is_status = (addr == ADDR_WIDTH'(ADDR_STATUS));
   assign key_hit   = |key_sel;

   always_comb begin
      key_sel = '0;
      key_rd  = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (addr == KEY_BASE + ADDR_WIDTH'(i * KEY_STRIDE)) begin
            key_sel[i] = 1'b1;
            key_rd     = key_sh[i];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (is_sel)         rd_val = REG_WIDTH'(sel_sh);
      else if (is_ctrl)   rd_val = REG_WIDTH'({lock, pending});
      else if (is_status) rd_val = REG_WIDTH'({pending, commit_count});
      else                rd_val = key_rd;
   end

   // Shadow writes are refused while a commit is pending so the copied snapshot is the one software saw
   assign err = (read && write)
             || !(is_sel || is_ctrl || is_status || key_hit)
             || (write && is_status)
             || (write && (is_sel || key_hit) && (lock || pending))
             || (write && is_sel && (wdata >= REG_WIDTH'(NUM_KEYS)));

   assign wr_ok      = write && !err;
   assign commit_req = wr_ok && is_ctrl && wdata[CTRL_COMMIT];

   cipher_regfile_commit_ctrl u_commit_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .commit_req   (commit_req),
      .busy         (busy),
      .pending      (pending),
      .apply        (apply),
      .commit_count (commit_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata   <= '0;
         done    <= 1'b0;
         error   <= 1'b0;
         lock    <= 1'b0;
         sel_sh  <= '0;
         sel_act <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_sh[i]  <= KEY_RST[i*REG_WIDTH +: REG_WIDTH];
            key_act[i] <= KEY_RST[i*REG_WIDTH +: REG_WIDTH];
         end
      end else begin
         done  <= read || write;
         error <= (read || write) && err;
         rdata <= (read && !err) ? rd_val : '0;
         if (wr_ok && is_sel)  sel_sh <= wdata[SEL_W-1:0];
         if (wr_ok && is_ctrl) lock   <= wdata[CTRL_LOCK];
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (wr_ok && key_sel[i]) key_sh[i] <= wdata;
         end
         if (apply) begin
            sel_act <= sel_sh;
            for (int i = 0; i < NUM_KEYS; i++) key_act[i] <= key_sh[i];
         end
      end
   end

   assign select = REG_WIDTH'(sel_act);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_keys
      assign keys[g*REG_WIDTH +: REG_WIDTH] = key_act[g];
   end
endmodule

// File: tb/tb_cipher_regfile.sv
// tb/tb_cipher_regfile.sv - directed vector bench for cipher_regfile
module tb_cipher_regfile;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic        rd, wr, busy;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        done, error;
   logic [15:0] select;
   logic [47:0] keys;

   int n_vec  = 0;
   int n_miss = 0;

   localparam logic [47:0] KEYS_RST = 48'h0002_FFFF_0000;

   typedef struct {
      logic        r;
      logic        w;
      logic [7:0]  a;
      logic [15:0] d;
      logic [15:0] er;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   cipher_regfile dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .addr   (addr),
      .read   (rd),
      .write  (wr),
      .wdata  (wdata),
      .busy   (busy),
      .rdata  (rdata),
      .done   (done),
      .error  (error),
      .select (select),
      .keys   (keys)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
      rd = r; wr = w; addr = a; wdata = d;
      step();
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic access(input string nm, input logic r, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input logic [15:0] er, input logic ee);
      drive(r, w, a, d);
      check({nm, " done"},  64'(done),  64'd1);
      check({nm, " error"}, 64'(error), 64'(ee));
      check({nm, " rdata"}, 64'(rdata), 64'(er));
   endtask

   task automatic check_outputs(input string nm, input logic [15:0] es, input logic [47:0] ek);
      check({nm, " select"}, 64'(select), 64'(es));
      check({nm, " keys"},   64'(keys),   64'(ek));
   endtask

   initial begin
      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; busy = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      check("reset done",  64'(done),  64'd0);
      check("reset error", 64'(error), 64'd0);
      check("reset rdata", 64'(rdata), 64'd0);
      check_outputs("reset", 16'h0, KEYS_RST);

      //            r     w     addr   wdata     exp_rdata err
      tbl.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h04, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h12, 16'h0000, 16'hFFFF, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h14, 16'h0000, 16'h0002, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h02, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h03, 16'h0000, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 8'h10, 16'h1111, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h04, 16'h0123, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 8'h04, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h00, 16'h0003, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h00, 16'h0002, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0002, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h00, 16'h8001, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0002, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h16, 16'h0BAD, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 8'h11, 16'h0000, 16'h0000, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 8'h12, 16'h1234, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h12, 16'h0000, 16'h1234, 1'b0});

      foreach (tbl[i])
         access($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee);

      step();
      check("idle done",  64'(done),  64'd0);
      check("idle error", 64'(error), 64'd0);
      check_outputs("table no commit", 16'h0, KEYS_RST);

      // commit latency: active copy one edge after the request edge
      access("wr key0", 1'b0, 1'b1, 8'h10, 16'h0005, 16'h0, 1'b0);
      access("wr sel",  1'b0, 1'b1, 8'h00, 16'h0001, 16'h0, 1'b0);
      access("commit",  1'b0, 1'b1, 8'h02, 16'h0001, 16'h0, 1'b0);
      check_outputs("commit edge N", 16'h0, KEYS_RST);
      step();
      check_outputs("commit edge N+1", 16'h1, 48'h0002_1234_0005);
      access("status after commit", 1'b1, 1'b0, 8'h04, 16'h0, 16'h0001, 1'b0);
      access("ctrl after commit",   1'b1, 1'b0, 8'h02, 16'h0, 16'h0000, 1'b0);

      // commit held off by busy
      busy = 1'b1;
      access("wr key2", 1'b0, 1'b1, 8'h14, 16'h00AA, 16'h0, 1'b0);
      access("commit busy", 1'b0, 1'b1, 8'h02, 16'h0001, 16'h0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 3)      access("busy wr key0", 1'b0, 1'b1, 8'h10, 16'h0777, 16'h0, 1'b1);
         else if (k == 5) access("busy wr sel",  1'b0, 1'b1, 8'h00, 16'h0002, 16'h0, 1'b1);
         else             access($sformatf("busy status%0d", k), 1'b1, 1'b0, 8'h04, 16'h0, 16'h0101, 1'b0);
      end
      check_outputs("busy hold", 16'h1, 48'h0002_1234_0005);
      busy = 1'b0;
      step();
      check_outputs("busy released", 16'h1, 48'h00AA_1234_0005);
      access("status after busy", 1'b1, 1'b0, 8'h04, 16'h0, 16'h0002, 1'b0);
      access("key0 kept",         1'b1, 1'b0, 8'h10, 16'h0, 16'h0005, 1'b0);

      // write lock
      access("set lock",        1'b0, 1'b1, 8'h02, 16'h0002, 16'h0, 1'b0);
      access("rd ctrl lock",    1'b1, 1'b0, 8'h02, 16'h0,    16'h0002, 1'b0);
      access("locked wr key1",  1'b0, 1'b1, 8'h12, 16'h5678, 16'h0, 1'b1);
      access("rd key1 locked",  1'b1, 1'b0, 8'h12, 16'h0,    16'h1234, 1'b0);
      access("clr lock",        1'b0, 1'b1, 8'h02, 16'h0000, 16'h0, 1'b0);
      access("unlocked wr key1",1'b0, 1'b1, 8'h12, 16'h5678, 16'h0, 1'b0);
      access("rd key1",         1'b1, 1'b0, 8'h12, 16'h0,    16'h5678, 1'b0);

      // commit_count wrap: count is 2, 253 commits reach 255, one more wraps to 0
      for (int k = 0; k < 253; k++) begin
         drive(1'b0, 1'b1, 8'h02, 16'h0001);
         step();
      end
      access("status 255", 1'b1, 1'b0, 8'h04, 16'h0, 16'h00FF, 1'b0);
      access("commit 256", 1'b0, 1'b1, 8'h02, 16'h0001, 16'h0, 1'b0);
      step();
      access("status wrap", 1'b1, 1'b0, 8'h04, 16'h0, 16'h0000, 1'b0);
      check_outputs("after wrap", 16'h1, 48'h00AA_5678_0005);

      // reset while pending discards the commit
      busy = 1'b1;
      access("wr key0 pre-rst", 1'b0, 1'b1, 8'h10, 16'h0777, 16'h0, 1'b0);
      access("commit+lock",     1'b0, 1'b1, 8'h02, 16'h0003, 16'h0, 1'b0);
      access("pending status",  1'b1, 1'b0, 8'h04, 16'h0, 16'h0100, 1'b0);
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 8'h10, 16'h0);
      check("rst done",  64'(done),  64'd0);
      check("rst error", 64'(error), 64'd0);
      check("rst rdata", 64'(rdata), 64'd0);
      check_outputs("rst pending", 16'h0, KEYS_RST);
      rst_n = 1'b1;
      busy = 1'b0;
      step();
      step();
      check_outputs("rst no late commit", 16'h0, KEYS_RST);
      access("rst status", 1'b1, 1'b0, 8'h04, 16'h0, 16'h0000, 1'b0);
      access("rst ctrl",   1'b1, 1'b0, 8'h02, 16'h0, 16'h0000, 1'b0);
      access("rst key0",   1'b1, 1'b0, 8'h10, 16'h0, 16'h0000, 1'b0);
      access("rst sel",    1'b1, 1'b0, 8'h00, 16'h0, 16'h0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/cipher_regfile.md
# cipher_regfile

Parametrised register bank for the decryption top level: holds the cipher-select and NUM_KEYS cipher-key registers behind a single-port register access bus and drives the MUX/DEMUX select and key inputs of the cipher blocks. Software writes shadow registers. A commit request copies all shadows to the active outputs atomically, deferred until the datapath reports idle, so keys never change mid-message. Adds a write lock, a status register and strict bus error reporting.

## Interface
- ADDR_WIDTH, 8, register address width
- REG_WIDTH, 16, register/key width
- NUM_KEYS, 3, number of cipher channels/key registers (2..8)
- KEY_BASE, 8'h10, address of key 0
- KEY_STRIDE, 2, address step between keys
- KEY_RST, {16'h2, 16'hFFFF, 16'h0}, packed reset values, key i at slice i
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- addr  in  ADDR_WIDTH  register address
- read  in  1  read strobe, one access per cycle
- write  in  1  write strobe
- wdata  in  REG_WIDTH  write data
- busy  in  1  datapath processing a message; commit deferred while high
- rdata  out  REG_WIDTH  read data
- done  out  1  access completed
- error  out  1  access failed
- select  out  REG_WIDTH  active select, zero-extended from SEL_W = $clog2(NUM_KEYS) bits
- keys  out  NUM_KEYS*REG_WIDTH  active keys, key i at slice i

## Operation
- Map: 0x00 SELECT (shadow, RW, bits [SEL_W-1:0], upper bits read 0). 0x02 CTRL (RW: bit0 commit request, write-1 action, reads as pending; bit1 lock). 0x04 STATUS (RO: [7:0] commit_count, [8] pending). KEY_BASE+i*KEY_STRIDE: shadow key i (RW).
- Error cases (done=1, error=1, rdata=0, no state change): unmapped address; read&&write together; write to STATUS; write to SELECT/key while lock=1 or while PENDING.
- SELECT write with value >= NUM_KEYS: error, shadow unchanged.
- Valid read: rdata = register, error=0. Valid write: rdata=0.
- FSM IDLE/PENDING. IDLE + valid CTRL write with bit0=1 -> PENDING. PENDING && busy==0 -> copy all shadows to active, commit_count+1 (wraps 255->0), -> IDLE. Commit request while PENDING: accepted, no effect.
- CTRL lock bit is written on every valid CTRL write, independent of bit0.

## Timing
- Access sampled on edge N; rdata/done/error registered, valid after edge N, one-cycle pulse per access; all three return to 0 the cycle after a cycle with no strobe.
- Commit: earliest active update at edge N+1 after the request edge N; held off by busy for an unbounded time; applied at the first edge with PENDING and busy==0.
- Shadow write at edge N is visible on read from edge N+1; active outputs unaffected until commit.
- Reset (any edge with rst_n=0, including mid-PENDING): rdata=0, done=0, error=0, state IDLE, lock=0, commit_count=0, shadow and active select=0, shadow and active key i=KEY_RST[i]. A pending commit is discarded. Reset has priority over any access.

## Structure
- Package cipher_regfile_pkg: address constants (ADDR_SELECT, ADDR_CTRL, ADDR_STATUS), CTRL bit indices, state enum {ST_IDLE, ST_PENDING}.
- Sub-module cipher_regfile_commit_ctrl: FSM, busy deferral, commit_count, apply pulse. Top level holds decode, shadow/active registers and the response logic.

## Test plan
- Reset, then read 0x00, 0x04 and keys 0x10/0x12/0x14 -> 0, 0, 0x0000/0xFFFF/0x0002, done=1, error=0; outputs select=0 and keys=KEY_RST.
- Write key0=0x0005 and SELECT=1, busy=0, commit -> outputs unchanged until edge N+1, then keys[0]=5 and select=1; STATUS reads 0x001.
- Commit with busy=1 for 10 cycles -> STATUS bit8=1, key write errors, outputs hold; busy falls -> apply next edge, pending clears.
- Read 0x03, read+write to 0x10, write STATUS, SELECT=3 with NUM_KEYS=3 -> each gives done=1, error=1, rdata=0, no change.
- Set lock=1 via CTRL=0x2, write key1 -> error; CTRL=0x0, write key1 -> success.
- 256 commits -> commit_count wraps to 0; rst_n=0 during PENDING -> IDLE, outputs back to reset values.
